melody_sequencer: RTL

//  Programmable single-voice melody player and parametrised successor to the hard-coded prelude player.

---
 rtl/sound_pkg.sv | 24 ++
 rtl/score_ram.sv | 28 ++
 rtl/melody_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared types and constants for the melody player
package sound_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PLAY,
        S_GAP
    } state_e;

    // clkgen_sin maxval for each note of the prelude scale
    localparam int unsigned NOTE_D      = 266;
    localparam int unsigned NOTE_E      = 237;
    localparam int unsigned NOTE_FIS    = 211;
    localparam int unsigned NOTE_G      = 199;
    localparam int unsigned NOTE_A      = 177;
    localparam int unsigned NOTE_B      = 158;
    localparam int unsigned NOTE_C      = 149;
    localparam int unsigned NOTE_DHIGH  = 133;

    localparam int unsigned TICK_DIV_8K = 1250;

endpackage

// File: rtl/score_ram.sv
// rtl/score_ram.sv - score storage, synchronous write, registered read-first
module score_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 22,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q;

    // Both updates are non-blocking, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - programmable single-voice melody player
module melody_sequencer
    import sound_pkg::*;
#(
    parameter int PITCH_W   = 9,
    parameter int DUR_W     = 13,
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int TICK_DIV  = TICK_DIV_8K,
    parameter int GAP_TICKS = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PITCH_W-1:0] wr_pitch,
    input  logic [DUR_W-1:0]   wr_dur,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [ADDR_W-1:0]  last_idx,
    input  logic [1:0]         tempo_shift,
    output logic [PITCH_W-1:0] pitch_o,
    output logic               tone_en,
    output logic               note_strobe,
    output logic [ADDR_W-1:0]  note_idx,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = DUR_W + 3;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0]  last_q, last_d;
    logic [PITCH_W-1:0] pitch_q, pitch_d;
    logic [CNT_W-1:0]   dur_q, dur_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic               done_q, done_d;
    logic               strobe_q, strobe_d;

    logic [PITCH_W+DUR_W-1:0] rd_data;
    logic [PITCH_W-1:0]       rd_pitch;
    logic [DUR_W-1:0]         rd_dur;
    logic                     tick;
    logic                     advance;

    score_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (PITCH_W + DUR_W),
        .DEPTH  (DEPTH)
    ) u_score_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({wr_pitch, wr_dur}),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

    assign rd_pitch = rd_data[PITCH_W+DUR_W-1 -: PITCH_W];
    assign rd_dur   = rd_data[DUR_W-1:0];
    assign tick     = (presc_q == PRE_W'(TICK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        pitch_d  = pitch_q;
        dur_d    = dur_q;
        gap_d    = gap_q;
        presc_d  = presc_q;
        done_d   = 1'b0;
        strobe_d = 1'b0;
        advance  = 1'b0;

        if (state_q == S_PLAY || state_q == S_GAP) begin
            presc_d = tick ? '0 : presc_q + PRE_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    last_d  = last_idx;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                if (rd_dur == '0) begin
                    advance = 1'b1;
                end else begin
                    state_d  = S_PLAY;
                    pitch_d  = rd_pitch;
                    dur_d    = {3'b000, rd_dur} << tempo_shift;
                    presc_d  = '0;
                    strobe_d = (rd_pitch != '0);
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (dur_q == CNT_W'(1)) begin
                        if (GAP_TICKS == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = GAP_W'(GAP_TICKS);
                            presc_d = '0;
                        end
                    end else begin
                        dur_d = dur_q - CNT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_W'(1)) begin
                        advance = 1'b1;
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // End-of-entry handling shared by skipped entries and finished notes
        if (advance) begin
            if (idx_q == last_q) begin
                if (loop_en) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end else begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
        end

        if (stop) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            strobe_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            last_q   <= '0;
            pitch_q  <= '0;
            dur_q    <= '0;
            gap_q    <= '0;
            presc_q  <= '0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            pitch_q  <= pitch_d;
            dur_q    <= dur_d;
            gap_q    <= gap_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
            strobe_q <= strobe_d;
        end
    end

    assign pitch_o     = pitch_q;
    assign tone_en     = (state_q == S_PLAY) && (pitch_q != '0);
    assign note_strobe = strobe_q;
    assign note_idx    = idx_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;

endmodule
